// File: rtl/vga_pkg.sv
// Shared VGA timing types, the default 640x480@60 mode and the fetch FSM states.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
    };

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } polarity_e;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-region decode.
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_i,
    output logic [W-1:0] count_o,
    output logic         wrap_c,
    output logic         in_active_c,
    output logic         in_sync_c
);
    localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap_c      = (count_q == W'(TOTAL - 1));
    assign in_active_c = (count_q < W'(ACTIVE));
    assign in_sync_c   = (count_q >= W'(SYNC_START)) && (count_q < W'(SYNC_END));
    assign count_o     = count_q;

    always_comb begin
        count_d = count_q;
        if (step_i) begin
            count_d = wrap_c ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_scaler.sv
// VGA raster generator with integer upscaling of source coordinates and a
// per-source-line fetch handshake toward the line buffer.
module vga_timing_scaler
    import vga_pkg::*;
#(
    parameter int unsigned HACTIVE = 32'(VGA_640x480_60.h.active),
    parameter int unsigned HFP     = 32'(VGA_640x480_60.h.fp),
    parameter int unsigned HSYNC   = 32'(VGA_640x480_60.h.sync),
    parameter int unsigned HBP     = 32'(VGA_640x480_60.h.bp),
    parameter int unsigned VACTIVE = 32'(VGA_640x480_60.v.active),
    parameter int unsigned VFP     = 32'(VGA_640x480_60.v.fp),
    parameter int unsigned VSYNC   = 32'(VGA_640x480_60.v.sync),
    parameter int unsigned VBP     = 32'(VGA_640x480_60.v.bp),
    parameter int unsigned HPOL    = 32'(SYNC_ACTIVE_LOW),
    parameter int unsigned VPOL    = 32'(SYNC_ACTIVE_LOW),
    parameter int unsigned SCALE   = 2,
    parameter int unsigned HW      = 10,
    parameter int unsigned VW      = 10
) (
    input  logic          vgaClk,
    input  logic          rstN,
    input  logic          en,
    output logic          hSync,
    output logic          vSync,
    output logic          de,
    output logic          frameStart,
    output logic [HW-1:0] srcX,
    output logic [VW-1:0] srcY,
    output logic          lineReq,
    output logic [VW-1:0] reqRow,
    input  logic          lineAck,
    output logic          underrun
);
    localparam int unsigned SHIFT  = $clog2(SCALE);
    localparam int unsigned HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VACTIVE + VFP + VSYNC + VBP;
    localparam logic        H_LVL  = 1'(HPOL);
    localparam logic        V_LVL  = 1'(VPOL);

    if (HTOTAL > (32'd1 << HW)) begin : g_hw_check
        $error("HW too narrow to hold HTOTAL-1");
    end
    if (VTOTAL > (32'd1 << VW)) begin : g_vw_check
        $error("VW too narrow to hold VTOTAL-1");
    end
    if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_scale_check
        $error("SCALE must be 1, 2 or 4");
    end

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap, v_wrap, h_act, v_act, h_sync_c, v_sync_c;

    vga_axis_counter #(.ACTIVE(HACTIVE), .FP(HFP), .SYNC(HSYNC), .BP(HBP), .W(HW)) u_h_cnt (
        .clk(vgaClk), .rst_n(rstN), .step_i(en), .count_o(h),
        .wrap_c(h_wrap), .in_active_c(h_act), .in_sync_c(h_sync_c)
    );

    vga_axis_counter #(.ACTIVE(VACTIVE), .FP(VFP), .SYNC(VSYNC), .BP(VBP), .W(VW)) u_v_cnt (
        .clk(vgaClk), .rst_n(rstN), .step_i(en & h_wrap), .count_o(v),
        .wrap_c(v_wrap), .in_active_c(v_act), .in_sync_c(v_sync_c)
    );

    logic          de_c;
    logic          hsync_q, vsync_q, de_q, frame_start_q;
    logic [HW-1:0] src_x_q;
    logic [VW-1:0] src_y_q;

    assign de_c = h_act & v_act;

    // Output registers capture the decode of the current position, one en-cycle behind the counters.
    always_ff @(posedge vgaClk or negedge rstN) begin
        if (!rstN) begin
            hsync_q       <= ~H_LVL;
            vsync_q       <= ~V_LVL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            src_x_q       <= '0;
            src_y_q       <= '0;
        end else if (en) begin
            hsync_q       <= h_sync_c ? H_LVL : ~H_LVL;
            vsync_q       <= v_sync_c ? V_LVL : ~V_LVL;
            de_q          <= de_c;
            frame_start_q <= (h == '0) && (v == '0);
            src_x_q       <= de_c ? (h >> SHIFT) : '0;
            src_y_q       <= de_c ? (v >> SHIFT) : '0;
        end
    end

    logic [VW-1:0] nv_c;
    logic          fetch_c, deadline_c;

    // Request the next line's source row as soon as the current line's active part ends.
    assign nv_c       = v_wrap ? '0 : v + VW'(1);
    assign fetch_c    = en && (h == HW'(HACTIVE)) && (nv_c < VW'(VACTIVE))
                        && ((nv_c & VW'(SCALE - 1)) == '0);
    assign deadline_c = en && h_wrap;

    fetch_state_e  state_q;
    logic          line_req_q, underrun_q;
    logic [VW-1:0] req_row_q;

    always_ff @(posedge vgaClk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= FETCH_IDLE;
            line_req_q <= 1'b0;
            req_row_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (fetch_c) begin
                        state_q    <= FETCH_REQ;
                        line_req_q <= 1'b1;
                        req_row_q  <= nv_c >> SHIFT;
                    end
                end
                FETCH_REQ: begin
                    // An ack on the deadline clock still counts as on time.
                    if (lineAck) begin
                        state_q    <= FETCH_IDLE;
                        line_req_q <= 1'b0;
                    end else if (deadline_c) begin
                        state_q    <= FETCH_IDLE;
                        line_req_q <= 1'b0;
                        underrun_q <= 1'b1;
                    end
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign de         = de_q;
    assign frameStart = frame_start_q;
    assign srcX       = src_x_q;
    assign srcY       = src_y_q;
    assign lineReq    = line_req_q;
    assign reqRow     = req_row_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_vga_timing_scaler.sv
// Bench for vga_timing_scaler on a reduced 16x10 raster (8x6 visible, SCALE 2).
module tb_vga_timing_scaler;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned W  = 5;
    localparam logic [13:0] RST = {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0};

    logic         vgaClk = 1'b0;
    logic         rstN   = 1'b0;
    logic         en     = 1'b0;
    logic         lineAck = 1'b0;
    logic         hSync, vSync, de, frameStart, lineReq, underrun;
    logic [W-1:0] srcX, srcY, reqRow;
    logic [13:0]  outs;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    typedef struct {
        int   k;
        logic hs, vs, de, fs;
        int   sx, sy;
    } vec_t;

    vec_t vecs[16];
    int   ek[6] = '{24, 56, 152, 184, 216, 312};
    int   er[6] = '{1, 2, 0, 1, 2, 0};

    vga_timing_scaler #(
        .HACTIVE(HA), .HFP(HF), .HSYNC(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYNC(VS), .VBP(VB),
        .HPOL(0), .VPOL(0), .SCALE(2), .HW(W), .VW(W)
    ) dut (
        .vgaClk(vgaClk), .rstN(rstN), .en(en),
        .hSync(hSync), .vSync(vSync), .de(de), .frameStart(frameStart),
        .srcX(srcX), .srcY(srcY),
        .lineReq(lineReq), .reqRow(reqRow), .lineAck(lineAck), .underrun(underrun)
    );

    always #5 vgaClk = ~vgaClk;

    assign outs = {hSync, vSync, de, frameStart, srcX, srcY};

    // Expected outputs after en-cycle k, straight from the raster definition.
    function automatic logic [13:0] model(input int k);
        int  h, v;
        logic d;
        h = k % int'(HT);
        v = (k / int'(HT)) % int'(VT);
        d = (h < int'(HA)) && (v < int'(VA));
        return {!((h >= int'(HA + HF)) && (h < int'(HA + HF + HS))),
                !((v >= int'(VA + VF)) && (v < int'(VA + VF + VS))),
                d, (h == 0) && (v == 0),
                d ? 5'(h / 2) : 5'd0, d ? 5'(v / 2) : 5'd0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (en-cycles %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic chk14(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (en-cycles %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic clk_step(input logic en_v);
        en = en_v;
        @(posedge vgaClk);
        @(negedge vgaClk);
        if (en_v) ncyc++;
    endtask

    task automatic do_reset();
        @(negedge vgaClk);
        rstN = 1'b0; en = 1'b0; lineAck = 1'b0;
        repeat (2) @(negedge vgaClk);
        chk14("reset_outs", outs, RST);
        chk("reset_fetch", {lineReq, underrun, reqRow}, 0);
        rstN = 1'b1;
        ncyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int de_n, hs_n, vs_n, fs_n, r, wait_n;
        logic [13:0] e;

        vecs[0]  = '{0,   1, 1, 1, 1, 0, 0};
        vecs[1]  = '{1,   1, 1, 1, 0, 0, 0};
        vecs[2]  = '{3,   1, 1, 1, 0, 1, 0};
        vecs[3]  = '{7,   1, 1, 1, 0, 3, 0};
        vecs[4]  = '{8,   1, 1, 0, 0, 0, 0};
        vecs[5]  = '{10,  0, 1, 0, 0, 0, 0};
        vecs[6]  = '{12,  0, 1, 0, 0, 0, 0};
        vecs[7]  = '{13,  1, 1, 0, 0, 0, 0};
        vecs[8]  = '{21,  1, 1, 1, 0, 2, 0};
        vecs[9]  = '{36,  1, 1, 1, 0, 2, 1};
        vecs[10] = '{87,  1, 1, 1, 0, 3, 2};
        vecs[11] = '{96,  1, 1, 0, 0, 0, 0};
        vecs[12] = '{120, 1, 0, 0, 0, 0, 0};
        vecs[13] = '{139, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{144, 1, 1, 0, 0, 0, 0};
        vecs[15] = '{160, 1, 1, 1, 1, 0, 0};

        // Continuous enable: hand-computed raster points.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            while (ncyc < vecs[i].k + 1) clk_step(1'b1);
            chk14($sformatf("vec_k%0d", vecs[i].k), outs,
                  {vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].fs, 5'(vecs[i].sx), 5'(vecs[i].sy)});
        end

        // Enable 1-of-3: same sequence on en-cycles, held in between.
        do_reset();
        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        for (int c = 0; c < 3 * 170; c++) begin
            clk_step(c % 3 == 0);
            e = (ncyc == 0) ? RST : model(ncyc - 1);
            chk14("en_third", outs, e);
            if (c % 3 == 0 && ncyc <= int'(HT * VT)) begin
                de_n += int'(de);
                hs_n += int'(!hSync);
                vs_n += int'(!vSync);
                fs_n += int'(frameStart);
            end
        end
        chk("frame_de_count", de_n, int'(HA * VA));
        chk("frame_hsync_count", hs_n, int'(HS * VT));
        chk("frame_vsync_count", vs_n, int'(VS * HT));
        chk("frame_start_count", fs_n, 1);

        // Fetch handshake with ack three clocks after each request.
        do_reset();
        r = 0; wait_n = -1;
        for (int c = 0; c < 330; c++) begin
            clk_step(1'b1);
            if (wait_n >= 0) begin
                wait_n++;
            end else if (lineReq) begin
                if (r < 6) begin
                    chk("req_cycle", ncyc - 1, ek[r]);
                    chk("req_row", int'(reqRow), er[r]);
                end else begin
                    chk("req_extra", r, 6);
                end
                r++;
                wait_n = 0;
            end
            if (wait_n == 2) begin
                chk("req_hold", int'(lineReq), 1);
                lineAck = 1'b1;
            end else if (wait_n == 3) begin
                chk("req_drop_after_ack", int'(lineReq), 0);
                lineAck = 1'b0;
                wait_n = -1;
            end
        end
        chk("req_count", r, 6);
        chk("no_underrun", int'(underrun), 0);

        // No ack: deadline drops the request and latches underrun.
        do_reset();
        while (ncyc < 31) clk_step(1'b1);
        chk("ur_pending_req", int'(lineReq), 1);
        chk("ur_before_deadline", int'(underrun), 0);
        clk_step(1'b1);
        chk("ur_req_dropped", int'(lineReq), 0);
        chk("ur_set", int'(underrun), 1);
        while (ncyc < 57) clk_step(1'b1);
        chk("ur_next_req", int'(lineReq), 1);
        chk("ur_next_row", int'(reqRow), 2);
        chk("ur_sticky", int'(underrun), 1);
        while (ncyc < 64) clk_step(1'b1);
        chk("ur_drop2", int'(lineReq), 0);
        chk("ur_sticky2", int'(underrun), 1);

        // Asynchronous reset mid-frame, then restart at (0,0).
        while (ncyc < 70) clk_step(1'b1);
        #2;
        rstN = 1'b0;
        #1;
        chk14("async_rst_outs", outs, RST);
        chk("async_rst_fetch", {lineReq, underrun, reqRow}, 0);
        @(negedge vgaClk);
        rstN = 1'b1;
        ncyc = 0;
        for (int i = 0; i < 20; i++) begin
            clk_step(1'b1);
            chk14("restart", outs, model(ncyc - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
